// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with majority vote and ready/ack handshake
module uart_rx_param #(
    parameter int SIZE        = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_tick,
    input  logic            rxd,
    input  logic            rx_ack,
    output logic [SIZE-1:0] dq,
    output logic            rx_ready,
    output logic            frame_error,
    output logic            parity_error,
    output logic            rx_break,
    output logic            overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta, rxs;
    logic [CW-1:0]   cnt;
    logic            v0, v1;
    logic [SIZE-1:0] shreg;
    logic [IW-1:0]   bit_idx;
    logic            stop_idx;
    logic            par_bit;
    logic            fe_pend;
    logic            stop0_zero;
    logic            armed;

    logic wrap, dec_tick, dec, last_stop, commit;
    logic c_fe, c_pe, c_brk, c_first_zero;

    assign wrap      = sample_tick && (cnt == CNT_LAST);
    assign dec_tick  = sample_tick && (cnt == CNT_DEC);
    assign dec       = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    // Frame result as it stands at the last stop-bit decision
    assign c_fe         = fe_pend | ~dec;
    assign c_first_zero = (STOP_BITS == 1) ? ~dec : stop0_zero;
    assign c_pe         = (PARITY_MODE == 0) ? 1'b0 : ((^{shreg, par_bit}) ^ (PARITY_MODE == 2));
    assign c_brk        = (shreg == '0) && (PARITY_MODE == 0 || !par_bit) && c_first_zero;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE:   if (sample_tick && !rxs && armed) state_d = START;
            START:  if (dec_tick && dec) state_d = IDLE;
                    else if (wrap) state_d = DATA;
            DATA:   if (wrap && bit_idx == IW'(SIZE - 1))
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY: if (wrap) state_d = STOP;
            STOP:   if (dec_tick && last_stop) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            state_q      <= IDLE;
            cnt          <= '0;
            v0           <= 1'b1;
            v1           <= 1'b1;
            shreg        <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            par_bit      <= 1'b0;
            fe_pend      <= 1'b0;
            stop0_zero   <= 1'b0;
            armed        <= 1'b1;
            dq           <= '0;
            rx_ready     <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            rx_break     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            state_q <= state_d;

            if (state_q == IDLE || state_d == IDLE) cnt <= '0;
            else if (sample_tick) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            if (sample_tick && cnt == CNT_V0) v0 <= rxs;
            if (sample_tick && cnt == CNT_V1) v1 <= rxs;

            if (state_q == DATA && dec_tick) shreg <= {dec, shreg[SIZE-1:1]};
            if (state_q == START) bit_idx <= '0;
            else if (state_q == DATA && wrap) bit_idx <= bit_idx + 1'b1;
            if (state_q == PARITY && dec_tick) par_bit <= dec;

            if (state_q != STOP) begin
                stop_idx <= 1'b0;
                fe_pend  <= 1'b0;
            end else begin
                if (dec_tick) begin
                    if (!dec) fe_pend <= 1'b1;
                    if (!stop_idx) stop0_zero <= ~dec;
                end
                if (wrap) stop_idx <= 1'b1;
            end

            // A low stop bit disarms start detection until the line is seen idle
            if (commit && c_fe) armed <= 1'b0;
            else if (state_q == IDLE && rxs) armed <= 1'b1;

            if (commit && (!rx_ready || rx_ack)) begin
                dq           <= shreg;
                frame_error  <= c_fe;
                parity_error <= c_pe;
                rx_break     <= c_brk;
                rx_ready     <= 1'b1;
                overrun      <= 1'b0;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (rx_ready && rx_ack) begin
                rx_ready     <= 1'b0;
                frame_error  <= 1'b0;
                parity_error <= 1'b0;
                rx_break     <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       half_rate = 1'b0;
    logic       rxd_l [3];
    logic       ack_l [3];
    logic [7:0] dq_o  [3];
    logic       rdy_o [3];
    logic       fe_o  [3];
    logic       pe_o  [3];
    logic       brk_o [3];
    logic       ovr_o [3];
    logic       trace [0:399];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(negedge clk) tick = half_rate ? ~tick : 1'b1;

    // instance 0: 8N1, instance 1: 8E1, instance 2: 8N2
    uart_rx_param #(.SIZE(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .sample_tick(tick), .rxd(rxd_l[0]), .rx_ack(ack_l[0]),
        .dq(dq_o[0]), .rx_ready(rdy_o[0]), .frame_error(fe_o[0]), .parity_error(pe_o[0]),
        .rx_break(brk_o[0]), .overrun(ovr_o[0]));
    uart_rx_param #(.SIZE(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .sample_tick(tick), .rxd(rxd_l[1]), .rx_ack(ack_l[1]),
        .dq(dq_o[1]), .rx_ready(rdy_o[1]), .frame_error(fe_o[1]), .parity_error(pe_o[1]),
        .rx_break(brk_o[1]), .overrun(ovr_o[1]));
    uart_rx_param #(.SIZE(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .sample_tick(tick), .rxd(rxd_l[2]), .rx_ack(ack_l[2]),
        .dq(dq_o[2]), .rx_ready(rdy_o[2]), .frame_error(fe_o[2]), .parity_error(pe_o[2]),
        .rx_break(brk_o[2]), .overrun(ovr_o[2]));

    // {dq, frame_error, parity_error, break, overrun, rx_ready}
    function automatic logic [12:0] status(input int s);
        return {dq_o[s], fe_o[s], pe_o[s], brk_o[s], ovr_o[s], rdy_o[s]};
    endfunction

    // Reference model: outcome of one accepted frame from its line-level contents
    function automatic logic [12:0] model(input logic [7:0] d, input int pmode, input logic p,
                                          input logic s1, input logic s2);
        logic fe, pe, brk;
        fe  = !s1 || !s2;
        pe  = (pmode == 0) ? 1'b0 : (pmode == 1) ? (($countones(d) + p) % 2 != 0)
                                                 : (($countones(d) + p) % 2 == 0);
        brk = (d == 8'h00) && (pmode == 0 || !p) && !s1;
        return {d, fe, pe, brk, 1'b0, 1'b1};
    endfunction

    function automatic logic [15:0] frame_n1(input logic [7:0] d, input logic s);
        return {6'h3f, s, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_p1(input logic [7:0] d, input logic p);
        return {5'h1f, 1'b1, p, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_n2(input logic [7:0] d, input logic s1, input logic s2);
        return {5'h1f, s2, s1, d, 1'b0};
    endfunction

    task automatic send_frame(input int s, input logic [15:0] bits, input int nbits,
                              input int bitlen, input int ack_at);
        for (int c = 0; c < nbits * bitlen; c++) begin
            if (c < 400) trace[c] = rdy_o[s];
            rxd_l[s] = bits[c / bitlen];
            ack_l[s] = (c == ack_at);
            @(negedge clk);
        end
        rxd_l[s] = 1'b1;
        ack_l[s] = 1'b0;
    endtask

    task automatic ack_and_idle(input int s, input logic [7:0] d, input string name);
        logic [12:0] exp;
        ack_l[s] = 1'b1;
        @(negedge clk);
        ack_l[s] = 1'b0;
        exp = {d, 5'b00000};
        checks++;
        if (status(s) !== exp) begin
            errors++;
            $display("FAIL %s_ack got %b want %b", name, status(s), exp);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            rxd_l[s] = 1'b1;
            ack_l[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (status(s) !== 13'd0) begin
                errors++;
                $display("FAIL reset_state inst %0d got %b want %b", s, status(s), 13'd0);
            end
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [12:0] exp;
        send_frame(0, frame_n1(8'hA5, 1'b1), 10, 16, -1);
        checks++;
        if (trace[156] !== 1'b0) begin
            errors++;
            $display("FAIL ready_early got %b want 0", trace[156]);
        end
        checks++;
        if (trace[157] !== 1'b1) begin
            errors++;
            $display("FAIL ready_latency got %b want 1", trace[157]);
        end
        exp = model(8'hA5, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL basic_a5 got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'hA5, "basic");
    endtask

    task automatic test_false_start();
        logic [12:0] exp;
        rxd_l[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxd_l[0] = 1'b1;
        repeat (48) @(negedge clk);
        exp = {8'hA5, 5'b00000};
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL false_start got %b want %b", status(0), exp);
        end
        send_frame(0, frame_n1(8'h3C, 1'b1), 10, 16, -1);
        exp = model(8'h3C, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL after_false_start got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'h3C, "false_start");
    endtask

    task automatic test_parity();
        logic [12:0] exp;
        logic [7:0]  d;
        logic        p;
        for (int i = 0; i < 6; i++) begin
            d = (i < 2) ? 8'h07 : 8'($urandom);
            p = (i < 2) ? 1'(i) : 1'($urandom);
            send_frame(1, frame_p1(d, p), 11, 16, -1);
            exp = model(d, 1, p, 1'b1, 1'b1);
            checks++;
            if (status(1) !== exp) begin
                errors++;
                $display("FAIL parity d=%h p=%b got %b want %b", d, p, status(1), exp);
            end
            ack_and_idle(1, d, "parity");
        end
    endtask

    task automatic test_break();
        logic [12:0] exp;
        int          rises;
        logic        prev;
        rises = 0;
        prev  = rdy_o[0];
        rxd_l[0] = 1'b0;
        for (int c = 0; c < 40 * 16 + 64; c++) begin
            if (c == 40 * 16) rxd_l[0] = 1'b1;
            @(negedge clk);
            if (rdy_o[0] && !prev) rises++;
            prev = rdy_o[0];
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL break_commits got %0d want 1", rises);
        end
        exp = model(8'h00, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL break_flags got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'h00, "break");
        repeat (48) @(negedge clk);
        checks++;
        if (rdy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL break_retrigger got %b want 0", rdy_o[0]);
        end
    endtask

    task automatic test_overrun();
        logic [12:0] exp;
        send_frame(0, frame_n1(8'h11, 1'b1), 10, 16, -1);
        send_frame(0, frame_n1(8'h22, 1'b1), 10, 16, -1);
        exp = {8'h11, 5'b00011};
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL overrun_drop got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'h11, "overrun");
        send_frame(0, frame_n1(8'h11, 1'b1), 10, 16, -1);
        send_frame(0, frame_n1(8'h22, 1'b1), 10, 16, 156);
        exp = model(8'h22, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL ack_at_commit got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'h22, "ack_commit");
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] exp;
        send_frame(0, frame_n1(8'h5A, 1'b1), 10, 16, -1);
        send_frame(0, frame_n1(8'h5A, 1'b1), 4, 16, -1);
        rxd_l[0] = 1'b1;
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (status(0) !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_frame got %b want %b", status(0), 13'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(0, frame_n1(8'h5A, 1'b1), 10, 16, -1);
        exp = model(8'h5A, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL after_reset got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'h5A, "after_reset");
    endtask

    task automatic test_stop2();
        logic [12:0] exp;
        logic [7:0]  d;
        logic        s2;
        for (int i = 0; i < 4; i++) begin
            d  = (i == 0) ? 8'h5A : 8'($urandom);
            s2 = (i == 0) ? 1'b0 : 1'($urandom);
            send_frame(2, frame_n2(d, 1'b1, s2), 11, 16, -1);
            exp = model(d, 0, 1'b0, 1'b1, s2);
            checks++;
            if (status(2) !== exp) begin
                errors++;
                $display("FAIL stop2 d=%h s2=%b got %b want %b", d, s2, status(2), exp);
            end
            ack_and_idle(2, d, "stop2");
        end
    endtask

    task automatic test_random();
        logic [12:0] exp;
        logic [7:0]  d;
        logic        s;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) d = 8'h00;
            s = ($urandom_range(0, 3) != 0);
            send_frame(0, frame_n1(d, s), 10, 16, -1);
            exp = model(d, 0, 1'b0, s, 1'b1);
            checks++;
            if (status(0) !== exp) begin
                errors++;
                $display("FAIL random d=%h s=%b got %b want %b", d, s, status(0), exp);
            end
            ack_and_idle(0, d, "random");
        end
    endtask

    task automatic test_half_rate();
        logic [12:0] exp;
        half_rate = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(0, frame_n1(8'h96, 1'b1), 10, 32, -1);
        exp = model(8'h96, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (status(0) !== exp) begin
            errors++;
            $display("FAIL half_rate got %b want %b", status(0), exp);
        end
        ack_and_idle(0, 8'h96, "half_rate");
        half_rate = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            rxd_l[s] = 1'b1;
            ack_l[s] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_false_start();
        test_parity();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        test_stop2();
        test_random();
        test_half_rate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised oversampling UART receiver; successor to the fixed 8N1 RX.
- Configurable data width, parity mode and stop-bit count; 3-sample majority voting.
- Adds break detection, overrun detection and a READY/ACK output handshake.
- Sits beside TX and is driven by an oversampled tick from BAUD_GENERATOR (ZD output).

Parameters:
- SIZE, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, SAMPLE_TICK pulses per bit period (even, >=8).
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits checked (1 or 2).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- SAMPLE_TICK  in  1  one-CLK pulse, OVERSAMPLE per bit period.
- RXD  in  1  serial line, asynchronous, idle high.
- RX_ACK  in  1  consumer accepts DQ; meaningful only while RX_READY=1.
- DQ  out  SIZE  received word.
- RX_READY  out  1  DQ holds an unconsumed word.
- FRAME_ERROR  out  1  a stop bit of the word in DQ was sampled 0.
- PARITY_ERROR  out  1  parity mismatch in the word in DQ (always 0 when PARITY_MODE=0).
- BREAK  out  1  the word in DQ was a break frame.
- OVERRUN  out  1  sticky: a frame was dropped because DQ was unconsumed.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is asynchronous and active-high.
- Reset values: DQ=0 and all flags=0; FSM=IDLE; tick counter=0; 2-FF RXD synchroniser=1. Reset mid-frame aborts the frame with no flags set.
- Synchronisation: RXD passes through a 2-FF synchroniser; all logic uses the synchronised value (rxs).
- Tick counter:
  - Advances only on SAMPLE_TICK; range 0..OVERSAMPLE-1.
  - At OVERSAMPLE-1 it wraps to 0 and the FSM advances to the next bit.
- Majority vote: rxs is sampled on ticks at counts M-1, M and M+1, where M=OVERSAMPLE/2. The bit decision is the 2-of-3 majority, taken at count M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rxs=0 and the armed flag set, go to START with counter=0. After reset, armed=1.
  - START: decision 1 is a false start: return to IDLE with no flags and no output change. Decision 0 continues; at wrap go to DATA with bit index 0.
  - DATA: shift SIZE decisions in LSB first. After bit SIZE-1 wraps, go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: the decision is checked against the XOR of the data bits. Even mode requires the total count of ones to be even; odd mode requires it to be odd. At wrap go to STOP.
  - STOP: STOP_BITS decisions. Any 0 sets a pending frame error.
  - Commit: occurs at the mid-bit decision of the last stop bit, not at wrap, then the FSM returns to IDLE.
  - If any stop bit was 0, armed is cleared and re-set only once rxs=1 is seen in IDLE, so a held-low line does not retrigger.
- Commit (outputs registered, visible the CLK after the decision tick):
  - RX_READY=0, or RX_ACK=1 in the same cycle: DQ, FRAME_ERROR, PARITY_ERROR and BREAK are loaded; RX_READY=1.
  - RX_READY=1 and RX_ACK=0: the new frame is dropped; DQ and its flags are unchanged; OVERRUN=1.
- Break: data all 0, parity bit 0 (if present) and first stop bit 0. Sets BREAK=1 and FRAME_ERROR=1; DQ=0.
- RX_ACK:
  - With RX_READY=1 and no commit in the same cycle: clears RX_READY, FRAME_ERROR, PARITY_ERROR, BREAK and OVERRUN next cycle; DQ holds its value.
  - With RX_READY=0: ignored.
- SAMPLE_TICK=0 freezes the FSM and counter; the handshake still operates.

Test Plan:
- Setup for all scenarios: SIZE=8, OVERSAMPLE=16, PARITY_MODE=0, STOP_BITS=1, SAMPLE_TICK tied high (bit = 16 CLK) unless stated.
- Send 0xA5 8N1 -> RX_READY rises the CLK after the stop-bit mid-sample; DQ=0xA5; FRAME_ERROR=PARITY_ERROR=BREAK=0. RX_ACK pulse -> RX_READY=0 next cycle.
- RXD low for 5 CLK, then high -> no RX_READY; FSM back in IDLE. Then send 0x3C -> DQ=0x3C.
- PARITY_MODE=1: send 0x07 with parity bit 0 -> PARITY_ERROR=1, DQ=0x07. Repeat with parity bit 1 -> PARITY_ERROR=0.
- Hold RXD low for 40 bit periods, then high -> exactly one commit: DQ=0x00, BREAK=1, FRAME_ERROR=1. No second frame until the line has returned high.
- Send 0x11 (no ACK), then send 0x22:
  - Result: DQ=0x11, OVERRUN=1.
  - Repeat with RX_ACK asserted in the commit cycle of 0x22: DQ=0x22, RX_READY=1, OVERRUN=0.
- Assert RST during data bit 3 of a frame -> all outputs 0 immediately. The next clean 0x5A is received correctly; also run one case with STOP_BITS=2 and the second stop bit 0 -> FRAME_ERROR=1.
